// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side and serial-side signals of the UART receiver.
// The slave modport is the receiver's view. The master modport is the view of
// whatever drives the RX line and consumes the received bytes.
interface uart_rx_if;
  logic       rx;
  logic [7:0] dout;
  logic       valid;
  logic       busy;
  logic       frame_err;

  modport master (output rx, input dout, valid, busy, frame_err);
  modport slave  (input rx, output dout, valid, busy, frame_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. It samples each bit at mid-bit from a baud
// down-counter and emits every received byte as a one-cycle valid strobe.
// Optional feature macro: UART_RX_FRAME_CHECK_EN. When defined, a low stop bit
// raises frame_err instead of delivering the byte. The FSM then waits in
// WAIT_HIGH until the line returns high.
module uart_rx #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 9600
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int          CLOCKS_PER_BAUD = CLK_FREQ / BAUD;
  localparam int          HALF_BAUD       = CLOCKS_PER_BAUD / 2;
  localparam logic [31:0] FULL_LOAD       = 32'(CLOCKS_PER_BAUD - 1);
  localparam logic [31:0] HALF_LOAD       = 32'(HALF_BAUD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_RX_FRAME_CHECK_EN
    , WAIT_HIGH
`endif
  } state_t;

  state_t      state, state_next;
  logic        rx_meta, rx_s;
  logic [31:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  dout_q;
  logic        valid_q;
  logic        sample;
  logic        load_half, load_full, clr_bits, shift, deliver;
`ifdef UART_RX_FRAME_CHECK_EN
  logic        flag_err;
  logic        frame_err_q;
`endif

  assign sample = (cnt == 32'd0);

  // Two-flop synchronizer on the asynchronous RX pin; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking so rx_s takes last cycle's rx_meta; blocking here would collapse the two flops into one.
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_next = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    clr_bits   = 1'b0;
    shift      = 1'b0;
    deliver    = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
    flag_err   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          load_half  = 1'b1;
        end
      end
      START: begin
        if (sample) begin
          if (!rx_s) begin
            state_next = DATA;
            load_full  = 1'b1;
            clr_bits   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift     = 1'b1;
          load_full = 1'b1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
`ifdef UART_RX_FRAME_CHECK_EN
            flag_err   = 1'b1;
            state_next = WAIT_HIGH;
`else
            deliver    = 1'b1;
            state_next = IDLE;
`endif
          end
        end
      end
`ifdef UART_RX_FRAME_CHECK_EN
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Baud counter, bit counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 32'd0;
      bit_cnt <= 3'd0;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      if (load_half)          cnt <= HALF_LOAD;
      else if (load_full)     cnt <= FULL_LOAD;
      else if (state != IDLE) cnt <= cnt - 32'd1;

      if (clr_bits)   bit_cnt <= 3'd0;
      else if (shift) bit_cnt <= bit_cnt + 3'd1;

      if (deliver) dout_q <= shreg;
      valid_q <= deliver;
    end
  end

  // Receive shift register: LSB arrives first, so new bits enter at the top.
  always_ff @(posedge clk) begin
    // NOTE: shreg is not reset; it only reaches dout after eight fresh shifts, so stale contents are never visible.
    if (shift) shreg <= {rx_s, shreg[7:1]};
  end

`ifdef UART_RX_FRAME_CHECK_EN
  // One-cycle framing-error strobe.
  always_ff @(posedge clk) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= flag_err;
  end
  assign bus.frame_err = frame_err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver that pairs with the on-chip UART transmitter. It recovers 8N1 frames (one start bit, 8 data bits LSB-first, one stop bit, no parity) from an asynchronous serial line and emits each received byte as a one-cycle `valid` strobe with `dout`. It sits between the board RX pin and the command/loopback path, and its output is intended to feed a byte FIFO directly.

## Interface
- `CLK_FREQ`, default 25_000_000: clock frequency in Hz.
- `BAUD`, default 9600: line rate in bits/s.
- Derived `CLOCKS_PER_BAUD` = `CLK_FREQ/BAUD` (integer divide; 2604 at defaults).
- Derived `HALF_BAUD` = `CLOCKS_PER_BAUD/2` (1302 at defaults).
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset, synchronous and active-high.
- `rx`  in  1  asynchronous serial input; idles high.
- `dout`  out  8  last received byte; reset 8'h00; holds its value until the next good frame.
- `valid`  out  1  one-cycle strobe when `dout` is updated; reset 0.
- `busy`  out  1  high in any state other than IDLE; reset 0.
- `frame_err`  out  1  one-cycle strobe on a bad stop bit; reset 0. Tied 0 when the checking feature is compiled out.

## Operation
- Input synchronizer: two flip-flops on `rx`, both reset to 1. All decisions use the synchronized value `rx_s`.
- Baud counter: 32-bit down counter. Reloaded on state entry as described below, decremented every cycle outside IDLE.
- A "sample point" is a clock edge at which the counter reads 0.
- `bit_cnt`: 3 bits. `shreg`: 8 bits, shifts right, new bit enters at bit 7.
- FSM states: IDLE, START, DATA, STOP, plus WAIT_HIGH when `UART_RX_FRAME_CHECK_EN` is defined.
  - IDLE: when `rx_s==0`, go to START and load the counter with `HALF_BAUD-1`.
  - START, at the sample point:
    - `rx_s==0`: go to DATA, load `CLOCKS_PER_BAUD-1`, clear `bit_cnt`.
    - `rx_s==1`: glitch; return to IDLE with no output.
  - DATA, at each sample point:
    - `shreg <= {rx_s, shreg[7:1]}`, increment `bit_cnt`, reload `CLOCKS_PER_BAUD-1`.
    - When `bit_cnt==7`, go to STOP instead of staying in DATA.
  - STOP, at the sample point:
    - `rx_s==1`: `dout <= shreg`, pulse `valid`, go to IDLE.
    - `rx_s==0`: see Configuration.
  - WAIT_HIGH: stay until `rx_s==1`, then go to IDLE. This prevents a held-low line (break condition) from being decoded as repeated 0x00 frames.
- `valid` and `frame_err` are never high in the same cycle.
- Reset mid-frame: return to IDLE, drop the partial byte, no `valid`. `dout` is reset to 0.
- There is no ready/backpressure input. The consumer must accept every `valid`; an overrun is the consumer's responsibility.

## Timing
- A falling edge on `rx` is seen in `rx_s` 2 cycles later. Call the edge where the FSM leaves IDLE "T".
- Start bit sampled at T+`HALF_BAUD` (T+1302).
- Data bit k (k = 0..7) sampled at T+`HALF_BAUD`+`CLOCKS_PER_BAUD`*(k+1).
- Stop bit sampled at T+`HALF_BAUD`+9*`CLOCKS_PER_BAUD` (T+24738). `valid`/`dout` are registered on that edge and are visible for exactly the following cycle.
- Back-to-back frames: IDLE is re-entered half a bit before the end of the stop bit, so a start bit immediately following the stop bit is detected with no lost cycles.
- `busy` rises the cycle after T and falls the cycle after the stop sample (or after the glitch reject / WAIT_HIGH exit).

## Configuration
- Macro: `UART_RX_FRAME_CHECK_EN`.
- Defined:
  - A low stop bit pulses `frame_err` for one cycle.
  - `dout` is not updated and there is no `valid`.
  - The FSM goes to WAIT_HIGH.
- Undefined:
  - The stop bit is not checked: the byte is delivered with `valid` regardless of its value.
  - The FSM goes to IDLE.
  - `frame_err` is tied 0 and the WAIT_HIGH state does not exist.

## Test plan
- Fast-sim parameters for all scenarios except the last: `CLK_FREQ`=16, `BAUD`=1 (`CLOCKS_PER_BAUD`=16, `HALF_BAUD`=8).
- Clean frame 0xA5 at 16 cycles/bit:
  - `valid` pulses exactly once, 8+9*16 cycles after T.
  - `dout`=8'hA5, `frame_err`=0.
- Low glitch of 4 cycles on idle line:
  - START sample reads 1, FSM returns to IDLE.
  - No `valid`; `busy` high for 8 cycles.
- Back-to-back 0x00 then 0xFF, with no idle gap between frames:
  - Two `valid` pulses exactly 160 cycles apart.
  - `dout` 8'h00 then 8'hFF.
- Frame 0x3C with the stop bit driven low, then line held low for 50 cycles:
  - With the macro defined: `frame_err` pulses once, no `valid`, `dout` unchanged, `busy` stays high until `rx_s` returns high.
  - With the macro undefined: `valid` with `dout`=8'h3C.
- `rst` asserted for 1 cycle during data bit 3 of a frame, then a clean 0x81 frame:
  - No `valid` for the aborted frame.
  - The subsequent frame yields `dout`=8'h81.
- Default parameters, frame 0x55:
  - `valid` at T+24738.
  - `dout`=8'h55.
